// File: rtl/dmem_if_if.sv
// Data-memory bus bundle: req/ack handshake plus address, lane enables and data.
interface dmem_if_if #(
    parameter int unsigned ADDR_W = 32
) ();

    logic              bus_req;
    logic              bus_we;
    logic [ADDR_W-1:0] bus_addr;
    logic [3:0]        bus_be;
    logic [31:0]       bus_wdata;
    logic              bus_ack;
    logic [31:0]       bus_rdata;

    // Memory-stage side drives the request.
    modport master (
        output bus_req,
        output bus_we,
        output bus_addr,
        output bus_be,
        output bus_wdata,
        input  bus_ack,
        input  bus_rdata
    );

    // Cache/bus side answers with ack and read data.
    modport slave (
        input  bus_req,
        input  bus_we,
        input  bus_addr,
        input  bus_be,
        input  bus_wdata,
        output bus_ack,
        output bus_rdata
    );

endinterface

// File: rtl/dmem_if.sv
// Memory-stage data-memory interface.
// Turns a load/store op into one req/ack bus transaction with lane-aligned
// byte enables, returns the addressed lane shifted to bit 0, and stalls the
// pipeline while the transaction is outstanding.
// Optional: define MISALIGN_TRAP_EN to abort misaligned half/word accesses
// without a bus request; otherwise offsets are truncated to legal granularity.
module dmem_if #(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_valid,
    input  logic [5:0]  ex_type,
    input  logic [31:0] addr,
    input  logic [31:0] write_data,
    output logic        stall,
    output logic [31:0] dcache_data,
    output logic        bus_err,
    dmem_if_if.master   bus
);

    localparam int unsigned CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [3:0]        be_q, be_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [1:0]        eoff_q, eoff_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              err_q, err_d;

    logic       is_op;
    logic       is_store;
    logic       is_byte;
    logic       is_half;
    logic [1:0] off;
    logic [1:0] eoff;
    logic [3:0] be;
    logic       timeout_hit;
`ifdef MISALIGN_TRAP_EN
    logic       misalign;
`endif

    // Op decode: size class, direction and effective lane offset.
    always_comb begin
        is_op    = mem_valid && (ex_type >= 6'd21) && (ex_type <= 6'd28);
        is_store = (ex_type >= 6'd26);
        is_byte  = (ex_type == 6'd21) || (ex_type == 6'd24) || (ex_type == 6'd26);
        is_half  = (ex_type == 6'd22) || (ex_type == 6'd25) || (ex_type == 6'd27);
        off      = addr[1:0];
        if (is_byte) begin
            eoff = off;
            be   = 4'b0001 << off;
        end else if (is_half) begin
            eoff = {off[1], 1'b0};
            be   = 4'b0011 << {off[1], 1'b0};
        end else begin
            eoff = 2'b00;
            be   = 4'b1111;
        end
`ifdef MISALIGN_TRAP_EN
        misalign = (is_half && off[0]) || (!is_byte && !is_half && (off != 2'b00));
`endif
    end

    assign timeout_hit = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Pipeline hold: any op outside the DONE cycle waits.
    assign stall = is_op && (state_q != ST_DONE);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (is_op) begin
`ifdef MISALIGN_TRAP_EN
                    state_d = misalign ? ST_DONE : ST_WAIT;
`else
                    state_d = ST_WAIT;
`endif
                end
            end
            ST_WAIT: begin
                if (bus.bus_ack || timeout_hit) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output / datapath next values; ack takes priority over timeout.
    always_comb begin
        cnt_d   = cnt_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        eoff_d  = eoff_q;
        rdata_d = rdata_q;
        err_d   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (is_op) begin
                    cnt_d = '0;
`ifdef MISALIGN_TRAP_EN
                    if (misalign) begin
                        err_d   = 1'b1;
                        rdata_d = '0;
                    end else begin
                        req_d   = 1'b1;
                        we_d    = is_store;
                        addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        be_d    = be;
                        wdata_d = is_store ? (write_data << {eoff, 3'b000}) : 32'd0;
                        eoff_d  = eoff;
                    end
`else
                    req_d   = 1'b1;
                    we_d    = is_store;
                    addr_d  = {addr[ADDR_W-1:2], 2'b00};
                    be_d    = be;
                    wdata_d = is_store ? (write_data << {eoff, 3'b000}) : 32'd0;
                    eoff_d  = eoff;
`endif
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (bus.bus_ack) begin
                    req_d = 1'b0;
                    if (!we_q) begin
                        rdata_d = bus.bus_rdata >> {eoff_q, 3'b000};
                    end
                end else if (timeout_hit) begin
                    req_d   = 1'b0;
                    rdata_d = '0;
                    err_d   = 1'b1;
                end
            end
            default: begin
            end
        endcase
    end

    // Datapath registers; reset clears the bus request asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            eoff_q  <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            eoff_q  <= eoff_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    assign bus.bus_req   = req_q;
    assign bus.bus_we    = we_q;
    assign bus.bus_addr  = addr_q;
    assign bus.bus_be    = be_q;
    assign bus.bus_wdata = wdata_q;
    assign dcache_data   = rdata_q;
    assign bus_err       = err_q;

endmodule

// File: doc/dmem_if.md
Name: dmem_if

Overview:
- Memory-stage data-memory interface between the pipeline's load/store path and the data cache/bus.
- Takes the ex_type code, effective address and store data from LSU (write_data), and runs a req/ack bus transaction with lane-aligned byte enables.
- Returns the load word with the addressed lane shifted down to bit 0; LSU consumes this as dcache_data.
- Stalls the pipeline while a transaction is outstanding.

Parameters:
- ADDR_W, 32, width of bus_addr.
- TIMEOUT, 16, number of cycles to wait for bus_ack before aborting (must be ≥2).

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- mem_valid  input  1  memory stage holds a valid instruction
- ex_type  input  6  op code: 21 lb, 22 lh, 23 lw, 24 lbu, 25 lhu, 26 sb, 27 sh, 28 sw; other values are not memory ops
- addr  input  32  effective byte address
- write_data  input  32  store data from LSU, right-justified
- stall  output  1  hold the pipeline
- dcache_data  output  32  aligned load data to LSU
- bus_err  output  1  one-cycle pulse on timeout or misalign abort
- bus_req  output  1  request strobe
- bus_we  output  1  1 = write
- bus_addr  output  ADDR_W  word-aligned address, addr[ADDR_W-1:2],2'b00
- bus_be  output  4  byte enables
- bus_wdata  output  32  lane-aligned store data
- bus_ack  input  1  one-cycle completion; bus_rdata valid with it
- bus_rdata  input  32  read word

Behaviour:
- Reset values: bus_req=0, bus_we=0, bus_addr=0, bus_be=0, bus_wdata=0, dcache_data=0, bus_err=0; FSM=IDLE; timeout counter=0.
- Definitions:
  - op = mem_valid && 21 ≤ ex_type ≤ 28.
  - off = addr[1:0].
  - Byte ops: be = 4'b0001<<off.
  - Half ops: be = 4'b0011<<{off[1],1'b0}.
  - Word ops: be = 4'b1111.
- FSM states: IDLE, WAIT, DONE.
  - IDLE: on op, register bus_addr/bus_be/bus_we (ex_type ≥ 26). Register bus_wdata = write_data << (8*off); for loads, bus_wdata = 0. Set bus_req=1 and go to WAIT. The counter loads 0.
  - WAIT:
    - bus_req and all bus_* outputs stay stable until the transaction ends.
    - Counter increments each cycle.
    - On bus_ack: bus_req=0; for loads, dcache_data = bus_rdata >> (8*off) zero-filled; for stores, dcache_data is unchanged. Go to DONE.
    - If the counter reaches TIMEOUT-1 without ack: bus_req=0, dcache_data=0, bus_err pulses 1 cycle, go to DONE.
    - If bus_ack arrives on that same cycle, ack wins (no error).
  - DONE: one cycle, then unconditionally back to IDLE.
- stall (combinational) = op && state != DONE.
  - The first cycle of an op stalls; the pipeline advances at the DONE edge.
  - Minimum latency is 3 cycles with an ack in the first WAIT cycle.
- The upstream stage must present a new instruction (or mem_valid=0) in the cycle after DONE. An op present in IDLE always starts a new transaction, so back-to-back ops are legal.
- bus_ack while in IDLE or DONE is ignored.
- mem_valid dropping during WAIT does not cancel the transaction; it completes, then the FSM goes to IDLE.
- Reset mid-transaction: all outputs return to reset values asynchronously, and bus_req drops immediately.

Optional Feature:
- Macro: MISALIGN_TRAP_EN.
- Defined:
  - Misaligned ops (lh/lhu/sh with addr[0]=1; lw/sw with off≠0) issue no bus request.
  - IDLE → DONE directly with bus_err pulsed and dcache_data=0.
  - stall is asserted for exactly one cycle.
- Not defined: off is honoured only to the legal granularity.
  - Half ops use off[1] only; word ops use off=0.
  - The access proceeds normally and bus_err fires only on timeout.

Test Plan:
- lbu at addr 0x103, bus_rdata=0xAABBCCDD with ack 1 cycle after req → bus_be=1000, bus_addr=0x100, dcache_data=0x000000AA, stall high for 2 cycles then low for DONE.
- sh at addr 0x202, write_data=0x00001234 → bus_we=1, bus_be=1100, bus_wdata=0x12340000; the req is held stable through 3 wait cycles until ack.
- lw at 0x40, no ack, TIMEOUT=16 → bus_req drops after 16 WAIT cycles, bus_err is a single 1-cycle pulse, dcache_data=0, stall releases.
- Back-to-back sw 0x10 then lw 0x10, with ack immediate each time → two separate req bursts with one IDLE cycle between; the lw returns the stored word.
- Assert rst during WAIT → bus_req=0 in the same cycle without waiting for a clock edge, FSM in IDLE; a later op starts cleanly.
- MISALIGN_TRAP_EN, lw at 0x41 → no bus_req, bus_err pulse, stall 1 cycle. Without the macro → access to 0x40 with be=1111.
